// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the five-stage ARM core: RAW hazard detection, branch flush,
// SRAM wait-state sequencing and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_valid,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             clr_cnt,
    output logic             freeze_if,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze_all,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } sram_state_e;

    sram_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic match_exe;
    logic match_mem;
    logic hazard;
    logic sram_stall;

    // Does the ID instruction read the register written by the given stage?
    assign match_exe = (id_src1_valid & (id_src1 == exe_dest)) |
                       (id_two_src    & (id_src2 == exe_dest));
    assign match_mem = (id_src1_valid & (id_src1 == mem_dest)) |
                       (id_two_src    & (id_src2 == mem_dest));

    always_comb begin
        if (FWD_EN) begin
            hazard = exe_wb_en & exe_mem_r_en & match_exe;
        end else begin
            hazard = (exe_wb_en & match_exe) | (mem_wb_en & match_mem);
        end
    end

    assign sram_stall = ((state_q == S_IDLE) & mem_req & ~sram_ready) |
                        ((state_q == S_WAIT) & ~sram_ready);

    // DONE deliberately ignores mem_req: the completed instruction is still in MEM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_req) state_d = sram_ready ? S_DONE : S_WAIT;
            S_WAIT: if (sram_ready) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Freeze beats branch (the branch waits in the frozen EXE register); branch beats
    // hazard because the dependent ID instruction is discarded anyway.
    always_comb begin
        freeze_all = 1'b0;
        freeze_if  = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        if (!rst) begin
            if (sram_stall) begin
                freeze_all = 1'b1;
                freeze_if  = 1'b1;
            end else if (branch_taken) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hazard) begin
                freeze_if = 1'b1;
                flush_id  = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (freeze_if && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_if && !(&flush_cnt_q))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a forwarding instance (16-bit counters) and a
// non-forwarding instance (4-bit counters, to reach saturation quickly) share one stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_src1_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, sram_ready, clr_cnt;

    logic        freeze_if_a, flush_if_a, flush_id_a, freeze_all_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        freeze_if_b, flush_if_b, flush_id_b, freeze_all_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int errors = 0;
    int checks = 0;

    // Expected control encoding: {freeze_all, freeze_if, flush_if, flush_id}
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] HAZ  = 4'b0101;
    localparam logic [3:0] BR   = 4'b0011;
    localparam logic [3:0] FRZ  = 4'b1100;

    typedef struct packed {
        logic [3:0]  ctrl_a;
        logic [3:0]  ctrl_b;
        logic [15:0] stall_a;
        logic [15:0] flush_a;
        logic [3:0]  stall_b;
        logic [3:0]  flush_b;
    } exp_t;

    exp_t sb_q[$];

    logic [15:0] m_stall_a = '0, m_flush_a = '0;
    logic [3:0]  m_stall_b = '0, m_flush_b = '0;

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
        .clr_cnt(clr_cnt),
        .freeze_if(freeze_if_a), .flush_if(flush_if_a), .flush_id(flush_id_a),
        .freeze_all(freeze_all_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
        .clr_cnt(clr_cnt),
        .freeze_if(freeze_if_b), .flush_if(flush_if_b), .flush_id(flush_id_b),
        .freeze_all(freeze_all_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src1_valid = 1'b0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0; clr_cnt = 1'b0;
    endtask

    // Called 1 time unit after a rising edge: settle, compare, advance one cycle.
    task automatic step(input string tag, input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        exp_t got;
        #2;
        if (rst) begin
            m_stall_a = '0; m_flush_a = '0; m_stall_b = '0; m_flush_b = '0;
        end
        e.ctrl_a  = ea;        e.ctrl_b  = eb;
        e.stall_a = m_stall_a; e.flush_a = m_flush_a;
        e.stall_b = m_stall_b; e.flush_b = m_flush_b;
        sb_q.push_back(e);

        got = sb_q.pop_front();
        cmp({tag, "_ctrl_a"}, {12'd0, freeze_all_a, freeze_if_a, flush_if_a, flush_id_a},
            {12'd0, got.ctrl_a});
        cmp({tag, "_ctrl_b"}, {12'd0, freeze_all_b, freeze_if_b, flush_if_b, flush_id_b},
            {12'd0, got.ctrl_b});
        cmp({tag, "_stall_a"}, stall_cnt_a, got.stall_a);
        cmp({tag, "_flush_a"}, flush_cnt_a, got.flush_a);
        cmp({tag, "_stall_b"}, {12'd0, stall_cnt_b}, {12'd0, got.stall_b});
        cmp({tag, "_flush_b"}, {12'd0, flush_cnt_b}, {12'd0, got.flush_b});

        if (!rst) begin
            if (clr_cnt) begin
                m_stall_a = '0; m_flush_a = '0; m_stall_b = '0; m_flush_b = '0;
            end else begin
                if (ea[2] && m_stall_a != 16'hFFFF) m_stall_a++;
                if (ea[1] && m_flush_a != 16'hFFFF) m_flush_a++;
                if (eb[2] && m_stall_b != 4'hF) m_stall_b++;
                if (eb[1] && m_flush_b != 4'hF) m_flush_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_inputs();
        clear_inputs();
        id_src1 = 4'd3; id_src1_valid = 1'b1;
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        mem_req = 1'b1; branch_taken = 1'b1;
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        step("reset", NONE, NONE);
        rst = 1'b0;
        clear_inputs();
        step("idle", NONE, NONE);

        // Load-use: one cycle with forwarding, two without
        load_use_inputs();
        step("load_use", HAZ, HAZ);
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
        step("load_in_mem", NONE, HAZ);
        clear_inputs();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        step("alu_dep_exe", NONE, HAZ);
        id_src1_valid = 1'b0; exe_mem_r_en = 1'b1;
        step("src1_not_read", NONE, NONE);

        // Second-source dependency on MEM
        clear_inputs();
        id_src2 = 4'd5; id_two_src = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
        step("src2_mem_dep", NONE, HAZ);
        id_two_src = 1'b0;
        step("src2_not_read", NONE, NONE);
        id_two_src = 1'b1; mem_wb_en = 1'b0;
        step("mem_no_wb", NONE, NONE);

        // Branch overrides hazard
        load_use_inputs();
        branch_taken = 1'b1;
        step("branch_over_haz", BR, BR);

        // SRAM: ready low for 4 cycles, branch arrives during the wait
        clear_inputs();
        mem_req = 1'b1;
        step("sram_idle_req", FRZ, FRZ);
        step("sram_wait1", FRZ, FRZ);
        branch_taken = 1'b1;
        step("sram_wait_br2", FRZ, FRZ);
        step("sram_wait_br3", FRZ, FRZ);
        sram_ready = 1'b1;
        step("sram_release_br", BR, BR);
        branch_taken = 1'b0; sram_ready = 1'b0;
        step("sram_done_ignores", NONE, NONE);
        step("sram_b2b_idle", FRZ, FRZ);
        sram_ready = 1'b1;
        step("sram_b2b_ready", NONE, NONE);
        sram_ready = 1'b0; mem_req = 1'b0;
        step("sram_b2b_done", NONE, NONE);

        // Zero-wait access
        mem_req = 1'b1; sram_ready = 1'b1;
        step("sram_fast", NONE, NONE);
        sram_ready = 1'b0;
        step("sram_fast_done", NONE, NONE);
        mem_req = 1'b0;
        step("sram_fast_idle", NONE, NONE);

        // Drive both counters of the 4-bit instance into saturation
        load_use_inputs();
        for (int i = 0; i < 18; i++) step("sat_stall", HAZ, HAZ);
        clear_inputs();
        branch_taken = 1'b1;
        for (int i = 0; i < 16; i++) step("sat_flush", BR, BR);
        clear_inputs();
        step("sat_hold", NONE, NONE);
        cmp("b_stall_saturated", {12'd0, stall_cnt_b}, 16'h000F);
        cmp("b_flush_saturated", {12'd0, flush_cnt_b}, 16'h000F);

        // Clear has priority over a concurrent increment
        load_use_inputs();
        clr_cnt = 1'b1;
        step("clr_with_stall", HAZ, HAZ);
        clear_inputs();
        step("after_clr", NONE, NONE);
        cmp("a_stall_cleared", stall_cnt_a, 16'h0000);

        // Reset in the middle of a wait abandons the access
        mem_req = 1'b1;
        step("rst_wait0", FRZ, FRZ);
        step("rst_wait1", FRZ, FRZ);
        rst = 1'b1; branch_taken = 1'b1;
        step("rst_mid_wait", NONE, NONE);
        rst = 1'b0; branch_taken = 1'b0;
        step("post_rst_idle_req", FRZ, FRZ);
        sram_ready = 1'b1;
        step("post_rst_ready", NONE, NONE);
        clear_inputs();
        step("post_rst_done", NONE, NONE);
        step("final_idle", NONE, NONE);

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline-control block for the ARM five-stage core. Every cycle it inspects the instruction in ID against destinations pending in EXE and MEM, the branch outcome from EXE, and the SRAM handshake from MEM. From these it drives the freeze and flush controls of the IF/ID/EXE/MEM pipeline registers. It owns the SRAM wait-state machine and two saturating performance counters (stall cycles, branch flushes).

## Interface
- FWD_EN, 1: 1 = forwarding unit present (only load-use hazards stall); 0 = stall on any RAW against EXE or MEM
- CNT_W, 16: width of performance counters
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_src1  in  4  Rn index of instruction in ID
- id_src1_valid  in  1  instruction in ID reads Rn
- id_src2  in  4  Rm/Rd-store index of instruction in ID
- id_two_src  in  1  instruction in ID reads second source
- exe_dest  in  4  destination register in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM instruction accesses SRAM (load or store)
- sram_ready  in  1  SRAM access complete this cycle
- clr_cnt  in  1  synchronous clear of both counters
- freeze_if  out  1  hold PC and IF/ID register
- flush_if  out  1  zero IF/ID register
- flush_id  out  1  zero ID/EXE register (bubble insert)
- freeze_all  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM; MEM/WB captures nothing
- stall_cnt  out  CNT_W  cycles with freeze_if=1
- flush_cnt  out  CNT_W  branch flushes applied

## Operation
- Source match: m1 = id_src1_valid & (id_src1 == d); m2 = id_two_src & (id_src2 == d).
- Hazard, FWD_EN=1: exe_wb_en & exe_mem_r_en & (m1|m2 vs exe_dest).
- Hazard, FWD_EN=0: (exe_wb_en & (m1|m2 vs exe_dest)) | (mem_wb_en & (m1|m2 vs mem_dest)).
- SRAM FSM, 2-bit state:
  - IDLE: stays while mem_req=0. On mem_req=1, goes to WAIT if sram_ready=0, otherwise to DONE.
  - WAIT: stays until sram_ready=1, then goes to DONE.
  - DONE: always returns to IDLE. Ignores mem_req for this cycle, because the same instruction still occupies MEM.
- freeze_all = (state==IDLE & mem_req & ~sram_ready) | (state==WAIT & ~sram_ready).
- Priority, highest first:
  1. freeze_all=1: freeze_if=1; flush_if=0; flush_id=0. A branch_taken arriving during the freeze is held by the frozen EXE register and takes effect on the release cycle.
  2. branch_taken=1: flush_if=1; flush_id=1; freeze_if=0. The branch overrides the hazard, because the ID instruction is discarded.
  3. hazard=1: freeze_if=1; flush_id=1; flush_if=0.
  4. Otherwise all control outputs are 0.
- stall_cnt increments when freeze_if=1. flush_cnt increments when flush_if=1 (branch). Both saturate at all-ones. clr_cnt has priority over increment.
- No special handling of register 15.

## Timing
- Hazard, branch and freeze outputs are combinational from inputs and state, valid in the same cycle.
- FSM state and counters update on the clk rising edge.
- Reset (asynchronous): state=IDLE, stall_cnt=0, flush_cnt=0.
  - While rst=1, all control outputs are forced to 0.
  - Reset asserted mid-WAIT abandons the access. After release the FSM re-evaluates mem_req from IDLE.
- Load-use stall lasts exactly 1 cycle with FWD_EN=1: the load advances to MEM and the hazard clears.
- With FWD_EN=0, a dependent instruction stalls up to 2 cycles.
- An SRAM access with first ready after N cycles gives N freeze_all cycles, then one DONE cycle with freeze_all=0.
- Back-to-back memory instructions each pay the full wait. DONE guarantees at least one advancing cycle between them.

## Test plan
- FWD_EN=1. ID: src1=3, src1_valid=1. EXE: load to r3 (exe_wb_en=1, exe_mem_r_en=1). Expected: freeze_if=1, flush_id=1 for 1 cycle; stall_cnt 0->1. The same case with exe_mem_r_en=0 gives no stall.
- FWD_EN=0. ID: src2=5, two_src=1. MEM: dest=5, mem_wb_en=1. Expected: freeze_if=1, flush_id=1. With id_two_src=0 there is no stall.
- mem_req=1, sram_ready low for 4 cycles, then high. Expected: freeze_all high for exactly 4 cycles; state WAIT->DONE->IDLE; stall_cnt +=4.
- branch_taken=1 together with a load-use hazard. Expected: flush_if=1, flush_id=1, freeze_if=0; flush_cnt +1.
- branch_taken=1 during SRAM WAIT. Expected: no flush until the DONE cycle, then flush_if=flush_id=1 once.
- Counters preloaded to 16'hFFFF with continued stalls stay at FFFF. clr_cnt=1 gives 0 next cycle. rst asserted mid-WAIT gives all outputs 0 immediately.
